// File: rtl/ebi_bridge_fifo_pkg.sv
// Shared types for the EBI bridge: read FSM states, write-entry layout and
// the default synchroniser depth.
package ebi_pkg;

  localparam int SYNC_STAGES_DEFAULT = 2;
  localparam int ENTRY_ADDR_W        = 16;
  localparam int ENTRY_DATA_W        = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RD_DRIVE = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [ENTRY_DATA_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/ebi_bridge_fifo_sync_fifo.sv
// Circular write buffer with occupancy count, registered head-valid and a
// sticky flag for pushes that arrive while the buffer is full.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     ready,
  output logic                     valid,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW:0]      count_r;
  logic [PW:0]      count_next_s;
  logic             valid_r;
  logic             overflow_r;
  logic             pop_s;
  logic             push_ok_s;

  // Pop frees a slot first, so a simultaneous push into a full buffer is kept
  always_comb begin
    pop_s        = valid_r & ready;
    push_ok_s    = push & ((count_r != (PW+1)'(DEPTH)) | pop_s);
    count_next_s = count_r + {{PW{1'b0}}, push_ok_s} - {{PW{1'b0}}, pop_s};
  end

  // Pointer, occupancy and flag state
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)     rd_ptr_r <= rd_ptr_r + PW'(1);
      count_r <= count_next_s;
      valid_r <= (count_next_s != '0);
      if (push & ~push_ok_s) overflow_r <= 1'b1;
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= din;
  end

  assign valid    = valid_r;
  assign dout     = mem_r[rd_ptr_r];
  assign count    = count_r;
  assign overflow = overflow_r;

endmodule

// File: rtl/ebi_bridge_fifo.sv
// EBI slave bridge: synchronises the multiplexed MCU bus into clk, buffers
// writes in a FIFO and serves reads through a request/acknowledge handshake.
module ebi_bridge_fifo
  import ebi_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int AUTO_INC    = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      EBI_AD_in,
  output logic [ADDR_W-1:0]      EBI_AD_out,
  output logic                   EBI_AD_oe,
  input  logic                   EBI_ALE,
  input  logic                   EBI_RE,
  input  logic                   EBI_WE,
  output logic                   wr_valid,
  input  logic                   wr_ready,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [DATA_W-1:0]      wr_data,
  output logic                   rd_req,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic                   rd_ack,
  input  logic [DATA_W-1:0]      rd_data,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic                   proto_err
);

  logic [SYNC_STAGES-1:0] ale_sync_r, re_sync_r, we_sync_r;
  logic [ADDR_W-1:0]      ad_sync_r [SYNC_STAGES];
  logic                   re_d_r, we_d_r;
  logic                   ale_s, re_s, we_s;
  logic [ADDR_W-1:0]      ad_s;
  logic                   we_rise_s, rd_start_s, rd_done_s;
  logic [ADDR_W-1:0]      inc_s;
  logic [ADDR_W-1:0]      addr_r;
  logic [DATA_W-1:0]      data_hold_r;
  logic                   proto_err_r;
  rd_state_e              state_r;
  logic [ADDR_W+DATA_W-1:0] entry_s;

  // Strobes and AD share one synchroniser depth so data stays aligned with strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      ale_sync_r <= '1;
      re_sync_r  <= '1;
      we_sync_r  <= '1;
      re_d_r     <= 1'b1;
      we_d_r     <= 1'b1;
      for (int i = 0; i < SYNC_STAGES; i++) ad_sync_r[i] <= '0;
    end else begin
      ale_sync_r   <= {ale_sync_r[SYNC_STAGES-2:0], EBI_ALE};
      re_sync_r    <= {re_sync_r[SYNC_STAGES-2:0], EBI_RE};
      we_sync_r    <= {we_sync_r[SYNC_STAGES-2:0], EBI_WE};
      re_d_r       <= re_sync_r[SYNC_STAGES-1];
      we_d_r       <= we_sync_r[SYNC_STAGES-1];
      ad_sync_r[0] <= EBI_AD_in;
      for (int i = 1; i < SYNC_STAGES; i++) ad_sync_r[i] <= ad_sync_r[i-1];
    end
  end

  // A read only starts when WE is idle; RE and WE low together is a protocol error
  always_comb begin
    ale_s      = ale_sync_r[SYNC_STAGES-1];
    re_s       = re_sync_r[SYNC_STAGES-1];
    we_s       = we_sync_r[SYNC_STAGES-1];
    ad_s       = ad_sync_r[SYNC_STAGES-1];
    we_rise_s  = we_s & ~we_d_r;
    rd_start_s = ~re_s & re_d_r & we_s;
    rd_done_s  = (state_r == RD_DRIVE) & re_s;
    inc_s      = ADDR_W'(we_rise_s) + ADDR_W'(rd_done_s);
  end

  // Address latch, write data hold and protocol-error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_r      <= '0;
      data_hold_r <= '0;
      proto_err_r <= 1'b0;
    end else begin
      if (!ale_s)              addr_r <= ad_s;
      else if (AUTO_INC != 0)  addr_r <= addr_r + inc_s;
      if (!we_s)               data_hold_r <= ad_s;
      if (!re_s && !we_s)      proto_err_r <= 1'b1;
    end
  end

  sync_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(ADDR_W + DATA_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (we_rise_s),
    .din      ({addr_r, data_hold_r}),
    .ready    (wr_ready),
    .valid    (wr_valid),
    .dout     (entry_s),
    .count    (fifo_count),
    .overflow (overflow)
  );

  assign wr_addr   = entry_s[ADDR_W+DATA_W-1:DATA_W];
  assign wr_data   = entry_s[DATA_W-1:0];
  assign proto_err = proto_err_r;

  // Read FSM; RE returning high before the ack aborts, so a late ack is ignored
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      rd_req     <= 1'b0;
      rd_addr    <= '0;
      EBI_AD_out <= '0;
      EBI_AD_oe  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (rd_start_s) begin
            state_r <= RD_WAIT;
            rd_req  <= 1'b1;
            rd_addr <= addr_r;
          end
        end
        RD_WAIT: begin
          if (re_s) begin
            rd_req  <= 1'b0;
            state_r <= IDLE;
          end else if (rd_ack) begin
            rd_req     <= 1'b0;
            EBI_AD_out <= rd_data;
            EBI_AD_oe  <= 1'b1;
            state_r    <= RD_DRIVE;
          end
        end
        RD_DRIVE: begin
          if (re_s) begin
            EBI_AD_oe <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          rd_req    <= 1'b0;
          EBI_AD_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ebi_bridge_fifo.md
Name: ebi_bridge_fifo

Overview:
- Parametrised successor of the EBI slave interface between the MCU's multiplexed external bus (ALE/RE/WE, active low) and FPGA logic.
- Synchronises asynchronous EBI strobes into clk.
- Latches address, then buffers writes in a FIFO with valid/ready drain.
- Services reads with a request/acknowledge handshake, drives read data back onto the bus, and supports optional address auto-increment for burst transfers.

Parameters:
- ADDR_W, 16, width of latched address and EBI_AD.
- DATA_W, 16, data width; must equal ADDR_W (shared AD bus).
- DEPTH, 8, write FIFO entries; power of two, >= 2.
- SYNC_STAGES, 2, synchroniser flops for strobes and AD; >= 2.
- AUTO_INC, 0, when 1, address increments by 1 after each completed write or read.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- EBI_AD_in  in  ADDR_W  multiplexed address/data from pad.
- EBI_AD_out  out  ADDR_W  read data to pad.
- EBI_AD_oe  out  1  pad output enable.
- EBI_ALE  in  1  address latch enable, active low.
- EBI_RE  in  1  read strobe, active low.
- EBI_WE  in  1  write strobe, active low.
- wr_valid  out  1  FIFO head valid.
- wr_ready  in  1  consumer accepts head.
- wr_addr  out  ADDR_W  head address.
- wr_data  out  DATA_W  head data.
- rd_req  out  1  read request, level.
- rd_addr  out  ADDR_W  read address, stable while rd_req=1.
- rd_ack  in  1  read data valid, single-cycle.
- rd_data  in  DATA_W  read data.
- fifo_count  out  $clog2(DEPTH)+1  occupancy.
- overflow  out  1  sticky; write arrived while FIFO full.
- proto_err  out  1  sticky; RE and WE sampled low together.

Behaviour:
- Sync: ALE, RE, WE and AD each pass through SYNC_STAGES flops; strobes reset to 1, AD to 0. All decisions use the synchronised copies, so AD stays aligned with the strobes. Edge detect compares the last stage against one extra delay flop.
- Address capture: while sync ALE=0, addr_reg <= sync AD every cycle. Value at ALE rise is held.
- Write: while sync WE=0, data_hold <= sync AD. On sync WE rising edge, push {addr_reg, data_hold}.
- Full FIFO on push: entry is dropped, overflow <= 1, count unchanged.
- Pop when wr_valid & wr_ready. Push and pop in the same cycle while full: pop then push succeeds, no overflow.
- Push into empty FIFO: wr_valid=1 on the next cycle (push-to-valid latency 1).
- AUTO_INC=1: addr_reg increments on each push and each completed read, wrapping at 2^ADDR_W. A new ALE low overrides.
- Read FSM: IDLE -> RD_WAIT -> RD_DRIVE -> IDLE.
  - IDLE: on sync RE falling edge, go to RD_WAIT with rd_req=1 and rd_addr=addr_reg.
  - RD_WAIT: on rd_ack, rd_req=0, EBI_AD_out<=rd_data, EBI_AD_oe=1, go to RD_DRIVE. If sync RE returns to 1 before rd_ack, rd_req=0 and go to IDLE (abort); a late rd_ack in IDLE is ignored.
  - RD_DRIVE: hold output until sync RE=1. Then oe=0 on the same clock edge, go to IDLE; auto-increment applies here.
  - rd_ack and RE rise in the same cycle in RD_WAIT: treat as abort, oe stays 0.
- Reads do not stall the write FIFO; writes during RD_* are pushed normally.
- RE and WE both sampled low: proto_err <= 1. The write still pushes on WE rise; the read FSM ignores the RE fall.
- Reset (any time, including mid-burst): FSM IDLE, FIFO empty, fifo_count=0, wr_valid=0, rd_req=0, EBI_AD_oe=0, EBI_AD_out=0, addr_reg=0, overflow=0, proto_err=0, sync flops to idle levels.

Decomposition:
- Package ebi_pkg holds:
  - read FSM state enum (IDLE, RD_WAIT, RD_DRIVE);
  - write-entry struct {addr, data} for the default widths;
  - localparam SYNC_STAGES default.
- Sub-module sync_fifo (DEPTH, WIDTH=ADDR_W+DATA_W) contains pointers, count, full/empty and overflow detect.
- Synchroniser and FSM stay in the top.

Test Plan:
- ALE low with AD=5, then WE pulse with AD=50, wr_ready=1 -> one entry {addr=5, data=50}, wr_valid for 1 cycle, fifo_count returns to 0.
- wr_ready=0, DEPTH+1 writes to addr 0x10 with data 1..9 -> entries 1..8 retained in order, 9 dropped, overflow=1. Drain gives 1..8, then wr_valid=0.
- AUTO_INC=1: ALE addr 0xFFFE, three WE pulses data 0xA,0xB,0xC -> entries {FFFE,A},{FFFF,B},{0000,C}.
- ALE addr 0x20, RE low, rd_ack after 3 cycles with rd_data=0xBEEF -> rd_addr=0x20, EBI_AD_oe=1 with 0xBEEF until RE rise syncs, then oe=0.
- RE pulse shorter than ack latency, rd_ack arrives after RE rise -> oe never asserts, FSM IDLE, next read works normally.
- Reset asserted during RD_DRIVE with 3 FIFO entries -> oe=0, fifo_count=0, wr_valid=0, flags cleared on next cycle.
